mac_accumulator: RTL

- Streaming multiply-accumulate stage built around the existing `multiplier` block.
- Accepts operand pairs over a valid/ready handshake and registers each product.
- Accumulates products into a wide saturating accumulator.
- On an end-of-vector beat, emits the dot-product sum over a valid/ready output port for downstream consumers.

---
 rtl/mac_accumulator_pkg.sv | 19 +
 rtl/mac_accumulator_multiplier.sv | 19 +
 rtl/mac_accumulator.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mac_accumulator_pkg.sv
// Shared definitions for the MAC stage: accumulator state encoding and
// saturation limits for a given width and signedness.
package mac_accumulator_pkg;

  typedef enum logic {
    MAC_EMPTY   = 1'b0,
    MAC_PARTIAL = 1'b1
  } mac_state_e;

  // Limits are returned in 64 bits; callers truncate to their width (< 64).
  function automatic logic [63:0] sat_max(input logic sgn, input int w);
    return sgn ? ((64'd1 << (w - 1)) - 64'd1) : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] sat_min(input logic sgn, input int w);
    return sgn ? ~((64'd1 << (w - 1)) - 64'd1) : 64'd0;
  endfunction

endpackage

// File: rtl/mac_accumulator_multiplier.sv
// Combinational WIDTH x WIDTH multiplier, signed or unsigned per the sign
// input; the 2*WIDTH product holds either interpretation exactly.
module multiplier #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sign,
  output logic [2*WIDTH-1:0] prod
);

  logic [2*WIDTH-1:0] ax, bx;

  // Low 2*WIDTH bits of the product of the extended operands are exact.
  assign ax   = {{WIDTH{sign & a[WIDTH-1]}}, a};
  assign bx   = {{WIDTH{sign & b[WIDTH-1]}}, b};
  assign prod = ax * bx;

endmodule

// File: rtl/mac_accumulator.sv
// Streaming multiply-accumulate: product register (P), saturating
// accumulator FSM (A) and a held output register with valid/ready.
module mac_accumulator
  import mac_accumulator_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sign,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_ovf
);

  localparam int SW = ACC_WIDTH + 1;

  logic                 first, vsign, sign_eff;
  logic [2*WIDTH-1:0]   mul_prod, p_prod;
  logic                 p_valid, p_last, p_sign;
  logic                 stall, accept, consume;
  mac_state_e           st, st_nxt;
  logic [ACC_WIDTH-1:0] acc, acc_nxt, base, sat_sum, lim_hi, lim_lo;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt, cnt_base, cnt_inc;
  logic                 ovf, ovf_nxt, ovf_acc, clamp_hi, clamp_lo, load_out;
  logic [SW-1:0]        base_x, prod_x, sum;

  assign stall    = p_valid & p_last & out_valid & ~out_ready;
  assign in_ready = ~p_valid | ~stall;
  assign accept   = in_valid & in_ready;
  assign consume  = p_valid & ~stall;

  // 'first' tracks vector boundaries at the input so a vector starting right
  // behind a pending last beat still samples its own sign.
  assign sign_eff = first ? sign : vsign;

  multiplier #(.WIDTH(WIDTH)) u_mul (
    .a    (a),
    .b    (b),
    .sign (sign_eff),
    .prod (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first   <= 1'b1;
      vsign   <= 1'b0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      p_sign  <= 1'b0;
      p_prod  <= '0;
    end else if (accept) begin
      first   <= in_last;
      vsign   <= sign_eff;
      p_valid <= 1'b1;
      p_last  <= in_last;
      p_sign  <= sign_eff;
      p_prod  <= mul_prod;
    end else if (consume) begin
      p_valid <= 1'b0;
    end
  end

  // Accumulate in ACC_WIDTH+1 bits; the top two bits reveal overflow.
  assign base     = (st == MAC_EMPTY) ? '0 : acc;
  assign base_x   = {p_sign & base[ACC_WIDTH-1], base};
  assign prod_x   = {{(SW-2*WIDTH){p_sign & p_prod[2*WIDTH-1]}}, p_prod};
  assign sum      = base_x + prod_x;
  assign lim_hi   = ACC_WIDTH'(sat_max(p_sign, ACC_WIDTH));
  assign lim_lo   = ACC_WIDTH'(sat_min(p_sign, ACC_WIDTH));
  assign clamp_hi = p_sign ? (~sum[SW-1] & sum[SW-2]) : sum[SW-1];
  assign clamp_lo = p_sign & sum[SW-1] & ~sum[SW-2];
  assign sat_sum  = clamp_hi ? lim_hi : (clamp_lo ? lim_lo : sum[ACC_WIDTH-1:0]);

  assign cnt_base = (st == MAC_EMPTY) ? '0 : cnt;
  assign cnt_inc  = (&cnt_base) ? cnt_base : cnt_base + 1'b1;
  assign ovf_acc  = ((st == MAC_PARTIAL) & ovf) | clamp_hi | clamp_lo;

  always_comb begin
    st_nxt   = st;
    acc_nxt  = acc;
    cnt_nxt  = cnt;
    ovf_nxt  = ovf;
    load_out = 1'b0;
    if (consume) begin
      if (p_last) begin
        st_nxt   = MAC_EMPTY;
        acc_nxt  = '0;
        cnt_nxt  = '0;
        ovf_nxt  = 1'b0;
        load_out = 1'b1;
      end else begin
        st_nxt  = MAC_PARTIAL;
        acc_nxt = sat_sum;
        cnt_nxt = cnt_inc;
        ovf_nxt = ovf_acc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= MAC_EMPTY;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      st  <= st_nxt;
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
    end
  end

  // A last beat can only be consumed when the register is free or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      out_sum   <= sat_sum;
      out_count <= cnt_inc;
      out_ovf   <= ovf_acc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
